vga_write_arbiter: RTL and testbench
====================================

# vga_write_arbiter

Shares the single VGA text-memory write port (vga_addr / vga_we / vga_data, 80x30 cells) among several drawing FSMs: the player FSM, ghost FSMs and the maze drawer. After reset it clears the screen to a fill glyph. It then grants one write per cycle using round-robin arbitration. A requester can lock the port for atomic erase/redraw sequences. Writes to out-of-range addresses are dropped and counted. The block sits between the drawing FSMs and the VGA text RAM.

## Interface
Parameters:
- N_REQ, 4, number of requesters (2..8)
- ADDR_W, 12, VGA address width
- DATA_W, 16, VGA cell data width (attr<<8 | glyph)
- CELLS, 2400, number of valid cells (80x30); valid addresses are 0..CELLS-1
- FILL, 16'h0000, cell value written during the clear phase
- CLEAR_EN, 1, 1 = run the clear phase after reset; 0 = skip it

Ports (reset rst, synchronous, active-high; clock clk):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  N_REQ  bit i: requester i has a write pending
- req_lock  in  N_REQ  bit i: requester i keeps ownership after its current write
- req_addr  in  N_REQ*ADDR_W  requester i address at bits [i*ADDR_W +: ADDR_W]
- req_data  in  N_REQ*DATA_W  requester i data at bits [i*DATA_W +: DATA_W]
- req_ready  out  N_REQ  one-hot or zero; combinational grant
- vga_addr  out  ADDR_W  registered write address
- vga_we  out  1  registered write enable
- vga_data  out  DATA_W  registered write data
- init_done  out  1  high once the clear phase is complete
- drop_count  out  8  saturating count of dropped out-of-range writes

## Operation
- Two states: CLEAR and ARB. Reset enters CLEAR when CLEAR_EN=1, otherwise ARB.
- CLEAR state:
  - A counter clr runs 0..CELLS-1, one value per cycle.
  - Each cycle registers vga_addr=clr, vga_data=FILL, vga_we=1.
  - req_ready is all zeros.
  - After clr=CELLS-1 is issued, the block moves to ARB.
- ARB state, eligibility:
  - eligible = req_valid & (locked ? onehot(owner) : all ones).
- ARB state, grant:
  - The grant goes to the first eligible index, searching upward from ptr and wrapping at N_REQ.
  - req_ready[g] is driven high in the same cycle.
  - A transfer occurs when req_valid[g] & req_ready[g]. Requesters hold addr/data stable while valid and not ready.
- ARB state, on a transfer by g:
  - ptr <= (g+1) mod N_REQ.
  - owner <= g.
  - locked <= req_lock[g].
  - If req_addr[g] < CELLS: register vga_addr / vga_data and set vga_we=1.
  - Otherwise: vga_we=0, and drop_count increments, saturating at 255. The request is still acknowledged.
- ARB state, lock release without a transfer:
  - If locked and req_lock[owner]=0 with no transfer, locked <= 0 at that edge. Other requesters are not granted in that cycle.
  - While locked, a valid from a non-owner is stalled indefinitely. This is by design.
- No transfer: vga_we=0. vga_addr and vga_data hold their previous values.
- Address comparison is unsigned at full ADDR_W width.

## Timing
- Reset values:
  - vga_addr=0, vga_data=0, vga_we=0
  - init_done=0, drop_count=0
  - req_ready=0 during the reset cycle
  - ptr=0, locked=0, owner=0, clr=0
- CLEAR_EN=1:
  - The first edge with rst=0 registers addr 0, so vga_we=1 from the following cycle.
  - CELLS consecutive write cycles are issued (addr 0..CELLS-1).
  - init_done=1 on the edge after the last clear write is registered. req_ready may assert in that same cycle.
- CLEAR_EN=0: init_done=1 and ARB is active from the first edge with rst=0.
- Write latency: a transfer sampled at edge E is visible on vga_* during cycle E+1, i.e. one cycle.
- Throughput: one write per cycle. A single requester holding valid high gets back-to-back grants, whether or not it holds the lock.
- Reset asserted mid-clear or mid-lock: all state returns to reset values and the clear restarts from addr 0.
- init_done stays high until the next rst.

## Test plan
- Clear phase (CLEAR_EN=1, CELLS=2400, FILL=16'h0E20):
  - Expect 2400 consecutive vga_we=1 cycles, addresses 0..2399, data 0E20.
  - init_done rises the cycle after addr 2399 is presented.
  - req_ready=0 throughout the clear.
- Round-robin:
  - Stimulus: all 4 requesters valid continuously, unlocked, addresses 100+i.
  - Expect grant order 0,1,2,3,0,…
  - vga_addr follows 100,101,102,103 one cycle after each grant.
- Lock:
  - Stimulus: requester 2 asserts lock for 3 writes (addr 500,501,502) while requesters 0, 1 and 3 are valid.
  - Expect three consecutive grants to 2, then a grant to 3 (ptr=3).
- Drop:
  - Stimulus: requester 1 writes addr 2400, then addr 4095.
  - Expect both acknowledged, vga_we=0 for both, drop_count=2.
  - After 300 further drops, drop_count holds at 255.
- Lock release while idle:
  - Stimulus: owner 0 locked, deasserts valid and lock together while requester 3 is valid.
  - Expect one idle cycle, then a grant to 3.
- Mid-operation reset:
  - Stimulus: rst pulsed during a lock held by requester 1 (CLEAR_EN=0).
  - Expect next cycle: locked=0, ptr=0, init_done=1, and a grant to 0 if it is valid.

Source files
------------

// File: rtl/vga_write_arbiter.sv
// Shares the VGA text-RAM write port among drawing FSMs: clears the screen after reset, then
// grants one write per cycle round-robin, with per-requester locking and out-of-range drop counting.
module vga_write_arbiter #(
    parameter int unsigned        N_REQ    = 4,
    parameter int unsigned        ADDR_W   = 12,
    parameter int unsigned        DATA_W   = 16,
    parameter int unsigned        CELLS    = 2400,
    parameter logic [DATA_W-1:0]  FILL     = '0,
    parameter bit                 CLEAR_EN = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid_i,
    input  logic [N_REQ-1:0]           req_lock_i,
    input  logic [N_REQ*ADDR_W-1:0]    req_addr_i,
    input  logic [N_REQ*DATA_W-1:0]    req_data_i,
    output logic [N_REQ-1:0]           req_ready_o,
    output logic [ADDR_W-1:0]          vga_addr_o,
    output logic                       vga_we_o,
    output logic [DATA_W-1:0]          vga_data_o,
    output logic                       init_done_o,
    output logic [7:0]                 drop_count_o
);

    localparam int unsigned PtrW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [PtrW-1:0]   LastIdx = PtrW'(N_REQ - 1);
    localparam logic [ADDR_W-1:0] LastClr = ADDR_W'(CELLS - 1);
    // CELLS may exceed the address space; clamp so the compare stays exact at ADDR_W+1 bits.
    localparam int unsigned       CellsClamp = (CELLS > (1 << ADDR_W)) ? (1 << ADDR_W) : CELLS;
    localparam logic [ADDR_W:0]   CellsExt   = CellsClamp[ADDR_W:0];

    typedef enum logic {StClear, StArb} state_e;
    localparam state_e ResetState = CLEAR_EN ? StClear : StArb;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   clr_q, clr_d;
    logic [PtrW-1:0]     ptr_q, ptr_d;
    logic [PtrW-1:0]     owner_q, owner_d;
    logic                locked_q, locked_d;
    logic [ADDR_W-1:0]   vga_addr_q, vga_addr_d;
    logic [DATA_W-1:0]   vga_data_q, vga_data_d;
    logic                vga_we_q, vga_we_d;
    logic                init_done_q, init_done_d;
    logic [7:0]          drop_q, drop_d;

    logic [ADDR_W-1:0]   addr_arr [N_REQ];
    logic [DATA_W-1:0]   data_arr [N_REQ];
    logic [N_REQ-1:0]    owner_oh;
    logic [N_REQ-1:0]    eligible;
    logic                found_hi, found_lo, gnt_found;
    logic [PtrW-1:0]     idx_hi, idx_lo, gnt_idx;
    logic                arb_active;
    logic                xfer;
    logic [ADDR_W-1:0]   g_addr;
    logic [DATA_W-1:0]   g_data;
    logic                in_range;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            addr_arr[i] = req_addr_i[i*ADDR_W +: ADDR_W];
            data_arr[i] = req_data_i[i*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        owner_oh          = '0;
        owner_oh[owner_q] = 1'b1;
        eligible          = locked_q ? (req_valid_i & owner_oh) : req_valid_i;
    end

    // Round-robin: first eligible index at or above ptr, else first eligible from zero.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        idx_hi   = '0;
        idx_lo   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found_hi && eligible[i] && (PtrW'(i) >= ptr_q)) begin
                found_hi = 1'b1;
                idx_hi   = PtrW'(i);
            end
            if (!found_lo && eligible[i]) begin
                found_lo = 1'b1;
                idx_lo   = PtrW'(i);
            end
        end
        gnt_found = found_hi | found_lo;
        gnt_idx   = found_hi ? idx_hi : idx_lo;
    end

    assign arb_active = (state_q == StArb) && !rst;
    assign xfer       = arb_active && gnt_found;
    assign g_addr     = addr_arr[gnt_idx];
    assign g_data     = data_arr[gnt_idx];
    assign in_range   = ({1'b0, g_addr} < CellsExt);

    always_comb begin
        req_ready_o = '0;
        if (xfer) begin
            req_ready_o[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        clr_d       = clr_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        locked_d    = locked_q;
        vga_we_d    = 1'b0;
        vga_addr_d  = vga_addr_q;
        vga_data_d  = vga_data_q;
        drop_d      = drop_q;
        init_done_d = init_done_q | (state_q == StArb);
        unique case (state_q)
            StClear: begin
                vga_we_d   = 1'b1;
                vga_addr_d = clr_q;
                vga_data_d = FILL;
                clr_d      = clr_q + 1'b1;
                if (clr_q == LastClr) begin
                    state_d = StArb;
                    clr_d   = '0;
                end
            end
            StArb: begin
                if (xfer) begin
                    ptr_d    = (gnt_idx == LastIdx) ? '0 : gnt_idx + 1'b1;
                    owner_d  = gnt_idx;
                    locked_d = req_lock_i[gnt_idx];
                    if (in_range) begin
                        vga_we_d   = 1'b1;
                        vga_addr_d = g_addr;
                        vga_data_d = g_data;
                    end else if (drop_q != 8'hFF) begin
                        drop_d = drop_q + 8'd1;
                    end
                end else if (locked_q && !req_lock_i[owner_q]) begin
                    locked_d = 1'b0;
                end
            end
            default: state_d = ResetState;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ResetState;
            clr_q       <= '0;
            ptr_q       <= '0;
            owner_q     <= '0;
            locked_q    <= 1'b0;
            vga_addr_q  <= '0;
            vga_data_q  <= '0;
            vga_we_q    <= 1'b0;
            init_done_q <= 1'b0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            clr_q       <= clr_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            locked_q    <= locked_d;
            vga_addr_q  <= vga_addr_d;
            vga_data_q  <= vga_data_d;
            vga_we_q    <= vga_we_d;
            init_done_q <= init_done_d;
            drop_q      <= drop_d;
        end
    end

    assign vga_addr_o   = vga_addr_q;
    assign vga_data_o   = vga_data_q;
    assign vga_we_o     = vga_we_q;
    assign init_done_o  = init_done_q;
    assign drop_count_o = drop_q;

endmodule

// File: tb/tb_vga_write_arbiter.sv
// Directed bench: clear phase on a CLEAR_EN=1 instance, arbitration/lock/drop/reset on a
// CLEAR_EN=0 instance, driven from a vector table plus a few hand-written sequences.
module tb_vga_write_arbiter;

    logic        clk;
    logic        rst_a, rst_b;
    logic [3:0]  valid, lock;
    logic [11:0] a0, a1, a2, a3;
    logic [47:0] addr_bus;
    logic [63:0] data_bus;

    logic [3:0]  ready_a, ready_b;
    logic [11:0] vaddr_a, vaddr_b;
    logic        we_a, we_b;
    logic [15:0] vdata_a, vdata_b;
    logic        init_a, init_b;
    logic [7:0]  drop_a, drop_b;

    int checks;
    int errors;

    assign addr_bus = {a3, a2, a1, a0};
    assign data_bus = {16'h1003, 16'h1002, 16'h1001, 16'h1000};

    vga_write_arbiter #(
        .N_REQ(4), .ADDR_W(12), .DATA_W(16), .CELLS(2400), .FILL(16'h0E20), .CLEAR_EN(1'b1)
    ) u_clr (
        .clk(clk), .rst(rst_a),
        .req_valid_i(valid), .req_lock_i(lock), .req_addr_i(addr_bus), .req_data_i(data_bus),
        .req_ready_o(ready_a), .vga_addr_o(vaddr_a), .vga_we_o(we_a), .vga_data_o(vdata_a),
        .init_done_o(init_a), .drop_count_o(drop_a)
    );

    vga_write_arbiter #(
        .N_REQ(4), .ADDR_W(12), .DATA_W(16), .CELLS(2400), .FILL(16'h0000), .CLEAR_EN(1'b0)
    ) u_arb (
        .clk(clk), .rst(rst_b),
        .req_valid_i(valid), .req_lock_i(lock), .req_addr_i(addr_bus), .req_data_i(data_bus),
        .req_ready_o(ready_b), .vga_addr_o(vaddr_b), .vga_we_o(we_b), .vga_data_o(vdata_b),
        .init_done_o(init_b), .drop_count_o(drop_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  lock;
        logic [11:0] a0, a1, a2, a3;
        logic [3:0]  rdy;
        logic        we;
        logic [11:0] addr;
        logic [15:0] data;
        logic [7:0]  drop;
    } vec_t;

    vec_t vecs [21];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        valid  = '0;
        lock   = '0;
        a0 = '0; a1 = '0; a2 = '0; a3 = '0;
        rst_a  = 1'b1;
        rst_b  = 1'b1;

        // Round-robin, 2-lock, single-requester drops, idle lock release, stalled non-owner.
        vecs[0]  = '{4'hF, 4'h0, 12'd100, 12'd101, 12'd102, 12'd103, 4'h1, 1'b1, 12'd100, 16'h1000, 8'd0};
        vecs[1]  = '{4'hF, 4'h0, 12'd100, 12'd101, 12'd102, 12'd103, 4'h2, 1'b1, 12'd101, 16'h1001, 8'd0};
        vecs[2]  = '{4'hF, 4'h0, 12'd100, 12'd101, 12'd102, 12'd103, 4'h4, 1'b1, 12'd102, 16'h1002, 8'd0};
        vecs[3]  = '{4'hF, 4'h0, 12'd100, 12'd101, 12'd102, 12'd103, 4'h8, 1'b1, 12'd103, 16'h1003, 8'd0};
        vecs[4]  = '{4'hF, 4'h0, 12'd100, 12'd101, 12'd102, 12'd103, 4'h1, 1'b1, 12'd100, 16'h1000, 8'd0};
        vecs[5]  = '{4'hF, 4'h0, 12'd100, 12'd101, 12'd102, 12'd103, 4'h2, 1'b1, 12'd101, 16'h1001, 8'd0};
        vecs[6]  = '{4'hF, 4'h4, 12'd100, 12'd101, 12'd500, 12'd103, 4'h4, 1'b1, 12'd500, 16'h1002, 8'd0};
        vecs[7]  = '{4'hF, 4'h4, 12'd100, 12'd101, 12'd501, 12'd103, 4'h4, 1'b1, 12'd501, 16'h1002, 8'd0};
        vecs[8]  = '{4'hF, 4'h0, 12'd100, 12'd101, 12'd502, 12'd103, 4'h4, 1'b1, 12'd502, 16'h1002, 8'd0};
        vecs[9]  = '{4'hB, 4'h0, 12'd100, 12'd101, 12'd502, 12'd103, 4'h8, 1'b1, 12'd103, 16'h1003, 8'd0};
        vecs[10] = '{4'h2, 4'h0, 12'd0, 12'd2400, 12'd0, 12'd0, 4'h2, 1'b0, 12'd103, 16'h1003, 8'd1};
        vecs[11] = '{4'h2, 4'h0, 12'd0, 12'd4095, 12'd0, 12'd0, 4'h2, 1'b0, 12'd103, 16'h1003, 8'd2};
        vecs[12] = '{4'h2, 4'h0, 12'd0, 12'd2399, 12'd0, 12'd0, 4'h2, 1'b1, 12'd2399, 16'h1001, 8'd2};
        vecs[13] = '{4'h1, 4'h1, 12'd7, 12'd0, 12'd0, 12'd0, 4'h1, 1'b1, 12'd7, 16'h1000, 8'd2};
        vecs[14] = '{4'h8, 4'h0, 12'd0, 12'd0, 12'd0, 12'd9, 4'h0, 1'b0, 12'd7, 16'h1000, 8'd2};
        vecs[15] = '{4'h8, 4'h0, 12'd0, 12'd0, 12'd0, 12'd9, 4'h8, 1'b1, 12'd9, 16'h1003, 8'd2};
        vecs[16] = '{4'h1, 4'h1, 12'd11, 12'd0, 12'd0, 12'd12, 4'h1, 1'b1, 12'd11, 16'h1000, 8'd2};
        vecs[17] = '{4'h8, 4'h1, 12'd11, 12'd0, 12'd0, 12'd12, 4'h0, 1'b0, 12'd11, 16'h1000, 8'd2};
        vecs[18] = '{4'h8, 4'h1, 12'd11, 12'd0, 12'd0, 12'd12, 4'h0, 1'b0, 12'd11, 16'h1000, 8'd2};
        vecs[19] = '{4'h8, 4'h0, 12'd11, 12'd0, 12'd0, 12'd12, 4'h0, 1'b0, 12'd11, 16'h1000, 8'd2};
        vecs[20] = '{4'h8, 4'h0, 12'd11, 12'd0, 12'd0, 12'd12, 4'h8, 1'b1, 12'd12, 16'h1003, 8'd2};

        repeat (3) @(posedge clk);
        #1;
        valid = 4'hF;
        #1;
        check("rst_ready_a", 32'(ready_a), 32'h0);
        check("rst_ready_b", 32'(ready_b), 32'h0);
        check("rst_we_a", 32'(we_a), 32'h0);
        check("rst_addr_a", 32'(vaddr_a), 32'h0);
        check("rst_init_a", 32'(init_a), 32'h0);
        check("rst_drop_a", 32'(drop_a), 32'h0);

        // Clear phase with requesters valid the whole time.
        @(posedge clk);
        #1;
        rst_a = 1'b0;
        #1;
        check("clr_ready_pre", 32'(ready_a), 32'h0);
        for (int n = 0; n < 2400; n++) begin
            @(posedge clk);
            #1;
            check($sformatf("clr_we[%0d]", n), 32'(we_a), 32'h1);
            check($sformatf("clr_addr[%0d]", n), 32'(vaddr_a), 32'(n));
            check($sformatf("clr_data[%0d]", n), 32'(vdata_a), 32'h0E20);
            check($sformatf("clr_init[%0d]", n), 32'(init_a), 32'h0);
            if (n < 2399) check($sformatf("clr_ready[%0d]", n), 32'(ready_a), 32'h0);
        end
        @(posedge clk);
        #1;
        check("clr_init_done", 32'(init_a), 32'h1);

        // Bring up the arbitration instance.
        valid = '0;
        @(posedge clk);
        #1;
        rst_b = 1'b0;
        check("b_rst_we", 32'(we_b), 32'h0);
        check("b_rst_addr", 32'(vaddr_b), 32'h0);
        check("b_rst_data", 32'(vdata_b), 32'h0);
        check("b_rst_init", 32'(init_b), 32'h0);
        @(posedge clk);
        #1;
        check("b_init_done", 32'(init_b), 32'h1);
        check("b_idle_ready", 32'(ready_b), 32'h0);
        check("a_init_holds", 32'(init_a), 32'h1);

        for (int v = 0; v < 21; v++) begin
            valid = vecs[v].valid;
            lock  = vecs[v].lock;
            a0 = vecs[v].a0; a1 = vecs[v].a1; a2 = vecs[v].a2; a3 = vecs[v].a3;
            #4;
            check($sformatf("v%0d_ready", v), 32'(ready_b), 32'(vecs[v].rdy));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_we", v), 32'(we_b), 32'(vecs[v].we));
            check($sformatf("v%0d_addr", v), 32'(vaddr_b), 32'(vecs[v].addr));
            check($sformatf("v%0d_data", v), 32'(vdata_b), 32'(vecs[v].data));
            check($sformatf("v%0d_drop", v), 32'(drop_b), 32'(vecs[v].drop));
        end

        // 300 more drops: counter saturates.
        valid = 4'h2;
        lock  = 4'h0;
        a1    = 12'd3000;
        for (int n = 0; n < 300; n++) begin
            #4;
            check($sformatf("sat_ready[%0d]", n), 32'(ready_b), 32'h2);
            @(posedge clk);
            #1;
        end
        check("sat_drop", 32'(drop_b), 32'hFF);
        check("sat_we", 32'(we_b), 32'h0);

        // Reset in the middle of a lock held by requester 1.
        valid = 4'h2;
        lock  = 4'h2;
        a1    = 12'd20;
        #4;
        check("ml_ready1", 32'(ready_b), 32'h2);
        @(posedge clk);
        #1;
        check("ml_addr1", 32'(vaddr_b), 32'd20);
        valid = 4'h3;
        a0    = 12'd33;
        #4;
        check("ml_locked_ready", 32'(ready_b), 32'h2);
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        #4;
        check("mr_rst_ready", 32'(ready_b), 32'h0);
        @(posedge clk);
        #1;
        rst_b = 1'b0;
        check("mr_we", 32'(we_b), 32'h0);
        check("mr_addr", 32'(vaddr_b), 32'h0);
        check("mr_drop", 32'(drop_b), 32'h0);
        check("mr_init", 32'(init_b), 32'h0);
        #3;
        check("mr_ready0", 32'(ready_b), 32'h1);
        @(posedge clk);
        #1;
        check("mr_init_done", 32'(init_b), 32'h1);
        check("mr_we0", 32'(we_b), 32'h1);
        check("mr_addr0", 32'(vaddr_b), 32'd33);
        check("mr_data0", 32'(vdata_b), 32'h1000);
        lock = 4'h0;
        #4;
        check("mr_ready1", 32'(ready_b), 32'h2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
